// File: rtl/kb_num_entry_pkg.sv
// kb_num_entry_pkg: shared constants and encodings for the numeric entry block.
// Holds set-2 scan codes, FSM state encoding and key-class encoding.
package kb_num_entry_pkg;

    localparam logic [7:0] SC_D0 = 8'h45;
    localparam logic [7:0] SC_D1 = 8'h16;
    localparam logic [7:0] SC_D2 = 8'h1E;
    localparam logic [7:0] SC_D3 = 8'h26;
    localparam logic [7:0] SC_D4 = 8'h25;
    localparam logic [7:0] SC_D5 = 8'h2E;
    localparam logic [7:0] SC_D6 = 8'h36;
    localparam logic [7:0] SC_D7 = 8'h3D;
    localparam logic [7:0] SC_D8 = 8'h3E;
    localparam logic [7:0] SC_D9 = 8'h46;

    localparam logic [7:0] SC_KP0 = 8'h70;
    localparam logic [7:0] SC_KP1 = 8'h69;
    localparam logic [7:0] SC_KP2 = 8'h72;
    localparam logic [7:0] SC_KP3 = 8'h7A;
    localparam logic [7:0] SC_KP4 = 8'h6B;
    localparam logic [7:0] SC_KP5 = 8'h73;
    localparam logic [7:0] SC_KP6 = 8'h74;
    localparam logic [7:0] SC_KP7 = 8'h6C;
    localparam logic [7:0] SC_KP8 = 8'h75;
    localparam logic [7:0] SC_KP9 = 8'h7D;

    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_CONV  = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        KC_OTHER = 3'd0,
        KC_DIGIT = 3'd1,
        KC_ENTER = 3'd2,
        KC_BKSP  = 3'd3,
        KC_ESC   = 3'd4
    } key_class_t;

endpackage

// File: rtl/kb_num_entry_scan_decode.sv
// kb_scan_decode: combinational scan-code classifier.
// In: key_code_i[7:0]. Out: kclass_o (key_class_t encoding), digit_o[3:0].
// KB_NUM_KEYPAD_EN: when defined, numeric keypad codes also decode as digits.
module kb_scan_decode
    import kb_num_entry_pkg::*;
(
    input  logic [7:0] key_code_i,
    output logic [2:0] kclass_o,
    output logic [3:0] digit_o
);

    always_comb begin
        kclass_o = KC_OTHER;
        digit_o  = 4'd0;
        case (key_code_i)
            SC_D0: begin kclass_o = KC_DIGIT; digit_o = 4'd0; end
            SC_D1: begin kclass_o = KC_DIGIT; digit_o = 4'd1; end
            SC_D2: begin kclass_o = KC_DIGIT; digit_o = 4'd2; end
            SC_D3: begin kclass_o = KC_DIGIT; digit_o = 4'd3; end
            SC_D4: begin kclass_o = KC_DIGIT; digit_o = 4'd4; end
            SC_D5: begin kclass_o = KC_DIGIT; digit_o = 4'd5; end
            SC_D6: begin kclass_o = KC_DIGIT; digit_o = 4'd6; end
            SC_D7: begin kclass_o = KC_DIGIT; digit_o = 4'd7; end
            SC_D8: begin kclass_o = KC_DIGIT; digit_o = 4'd8; end
            SC_D9: begin kclass_o = KC_DIGIT; digit_o = 4'd9; end
`ifdef KB_NUM_KEYPAD_EN
            SC_KP0: begin kclass_o = KC_DIGIT; digit_o = 4'd0; end
            SC_KP1: begin kclass_o = KC_DIGIT; digit_o = 4'd1; end
            SC_KP2: begin kclass_o = KC_DIGIT; digit_o = 4'd2; end
            SC_KP3: begin kclass_o = KC_DIGIT; digit_o = 4'd3; end
            SC_KP4: begin kclass_o = KC_DIGIT; digit_o = 4'd4; end
            SC_KP5: begin kclass_o = KC_DIGIT; digit_o = 4'd5; end
            SC_KP6: begin kclass_o = KC_DIGIT; digit_o = 4'd6; end
            SC_KP7: begin kclass_o = KC_DIGIT; digit_o = 4'd7; end
            SC_KP8: begin kclass_o = KC_DIGIT; digit_o = 4'd8; end
            SC_KP9: begin kclass_o = KC_DIGIT; digit_o = 4'd9; end
`endif
            SC_ENTER: kclass_o = KC_ENTER;
            SC_BKSP:  kclass_o = KC_BKSP;
            SC_ESC:   kclass_o = KC_ESC;
            default:  kclass_o = KC_OTHER;
        endcase
    end

endmodule

// File: rtl/kb_num_entry.sv
// kb_num_entry: pops scan codes, builds a BCD entry, converts it to binary on
// Enter and offers it on a valid/ready port. Ports: clk, reset, key_code,
// kb_buf_empty, rd_key_code, num, num_valid, num_ready, bcd, digit_cnt.
module kb_num_entry
    import kb_num_entry_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int W      = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            key_code,
    input  logic                  kb_buf_empty,
    output logic                  rd_key_code,
    output logic [W-1:0]          num,
    output logic                  num_valid,
    input  logic                  num_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [2:0]            digit_cnt
);

    state_t              state_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [2:0]          cnt_q;
    logic [2:0]          idx_q;
    logic [W-1:0]        acc_q;
    logic [W-1:0]        num_q;
    logic                valid_q;

    logic [2:0]          kclass;
    logic [3:0]          kdigit;
    logic [4*DIGITS+3:0] bcd_push;
    logic [4*DIGITS-1:0] bcd_sel;
    logic [3:0]          cur_dig;
    logic [W-1:0]        acc_d;

    kb_scan_decode u_dec (
        .key_code_i (key_code),
        .kclass_o   (kclass),
        .digit_o    (kdigit)
    );

    assign rd_key_code = (state_q == ST_ENTRY) & ~kb_buf_empty & ~reset;

    // Shift-in works for DIGITS=1 too; the top nibble simply falls off.
    assign bcd_push = {bcd_q, kdigit};
    assign bcd_sel  = bcd_q >> {idx_q, 2'b00};
    assign cur_dig  = bcd_sel[3:0];

    // acc*10 as shift-add; W is sized so this never wraps.
    assign acc_d = (acc_q << 3) + (acc_q << 1) + W'(cur_dig);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ENTRY;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (!kb_buf_empty) begin
                        case (kclass)
                            KC_DIGIT: begin
                                if (cnt_q < 3'(DIGITS)) begin
                                    bcd_q <= bcd_push[4*DIGITS-1:0];
                                    cnt_q <= cnt_q + 3'd1;
                                end
                            end
                            KC_BKSP: begin
                                if (cnt_q != 3'd0) begin
                                    bcd_q <= bcd_q >> 4;
                                    cnt_q <= cnt_q - 3'd1;
                                end
                            end
                            KC_ESC: begin
                                bcd_q <= '0;
                                cnt_q <= '0;
                            end
                            KC_ENTER: begin
                                if (cnt_q != 3'd0) begin
                                    acc_q   <= '0;
                                    idx_q   <= cnt_q - 3'd1;
                                    state_q <= ST_CONV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CONV: begin
                    // Walk from the oldest digit down to the newest.
                    acc_q <= acc_d;
                    if (idx_q == 3'd0) begin
                        num_q   <= acc_d;
                        valid_q <= 1'b1;
                        state_q <= ST_OUT;
                    end else begin
                        idx_q <= idx_q - 3'd1;
                    end
                end
                ST_OUT: begin
                    if (num_ready) begin
                        valid_q <= 1'b0;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_ENTRY;
                    end
                end
                default: state_q <= ST_ENTRY;
            endcase
        end
    end

    assign num       = num_q;
    assign num_valid = valid_q;
    assign bcd       = bcd_q;
    assign digit_cnt = cnt_q;

endmodule

// File: doc/kb_num_entry.md
# kb_num_entry

Downstream consumer of the keyboard scan-code buffer: pops scan codes from the key FIFO, recognises decimal digit, Enter, Backspace and Escape keys, and collects up to DIGITS decimal digits as a BCD entry. On Enter it converts the entry to binary over several cycles and presents it on a valid/ready port to the Fibonacci datapath. The BCD entry is also exported for the seven-segment display.

## Interface
- DIGITS, 2, maximum number of decimal digits in one entry (1..4)
- W, 7, width of binary result; must satisfy 2^W > 10^DIGITS − 1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_code  in  8  scan code at head of key FIFO; valid whenever kb_buf_empty=0 (first-word-fall-through)
- kb_buf_empty  in  1  key FIFO empty
- rd_key_code  out  1  pop strobe to key FIFO; one cycle per consumed code
- num  out  W  binary value of the completed entry
- num_valid  out  1  num is valid; held until accepted
- num_ready  in  1  consumer accepts num when num_valid=1 and num_ready=1
- bcd  out  4*DIGITS  current entry, digit 0 (LS nibble) = most recent digit
- digit_cnt  out  3  number of digits currently entered (0..DIGITS)

## Operation
- Scan codes (set 2): 0=45, 1=16, 2=1E, 3=26, 4=25, 5=2E, 6=36, 7=3D, 8=3E, 9=46, Enter=5A, Backspace=66, Escape=76 (hex). All other codes: popped and discarded.
- FSM states: ENTRY, CONV, OUT. Reset state ENTRY.
- ENTRY: rd_key_code = !kb_buf_empty (combinational, forced 0 while reset=1). Code decoded in the same cycle as the pop; registers update at the next edge.
  - Digit, digit_cnt<DIGITS: bcd <= {bcd[4*DIGITS-5:0], d}; digit_cnt+1.
  - Digit, digit_cnt=DIGITS: ignored (popped, no change).
  - Backspace: bcd <= bcd>>4; digit_cnt−1; ignored if digit_cnt=0.
  - Escape: bcd<=0, digit_cnt<=0.
  - Enter, digit_cnt=0: ignored. Enter, digit_cnt>0: acc<=0, idx<=digit_cnt−1, go CONV.
- CONV: rd_key_code=0. Each cycle acc <= acc*10 + bcd[idx]; acc*10 computed as (acc<<3)+(acc<<1) in W bits (no overflow by W rule). When idx=0, num<=final acc, num_valid<=1, go OUT; else idx−1.
- OUT: rd_key_code=0; num_valid=1, num stable. On num_ready=1: num_valid<=0, bcd<=0, digit_cnt<=0, go ENTRY.
- Keys arriving during CONV/OUT remain in the FIFO; none are lost unless the FIFO itself overflows.
- Reset mid-operation (any state): immediately ENTRY, all registers cleared, pending result discarded.

## Timing
- Reset values: rd_key_code=0, num=0, num_valid=0, bcd=0, digit_cnt=0.
- At most one code consumed per cycle in ENTRY; back-to-back pops permitted.
- Digit visible on bcd/digit_cnt 1 cycle after its pop.
- Enter popped at cycle t: CONV during t+1..t+digit_cnt; num_valid=1 from cycle t+digit_cnt+1.
- Handshake completes on the edge where num_valid&num_ready; earliest next pop is the following cycle.
- num_ready while num_valid=0 has no effect.

## Configuration
- KB_NUM_KEYPAD_EN defined: numeric keypad digits also accepted: 0=70, 1=69, 2=72, 3=7A, 4=6B, 5=73, 6=74, 7=6C, 8=75, 9=7D; behaviour identical to main-row digits.
- Not defined: keypad codes are discarded as unknown.

## Structure
- Shared package: scan-code constants (digits, keypad digits, ENTER, BKSP, ESC), FSM state encoding, key-class encoding (DIGIT, ENTER, BKSP, ESC, OTHER).
- Sub-module kb_scan_decode: combinational, key_code -> key class + 4-bit digit value; contains the KB_NUM_KEYPAD_EN conditional.

## Test plan
- Codes 16, 1E, 5A queued; num_ready=1 -> num=12, num_valid for one cycle starting 3 cycles after Enter pop; bcd cleared afterward.
- Codes 46, 46, 26, 5A (DIGITS=2) -> third digit ignored; num=99; digit_cnt never exceeds 2.
- Codes 26, 2E, 66, 3E, 5A -> bcd 0x35 then 0x03 then 0x38; num=38.
- Codes 5A alone, then 76 with empty entry, then 7C -> all popped, no num_valid, bcd=0.
- Entry 45,16,5A with num_ready=0 for 10 cycles while codes 1E queued -> num=1 held stable, rd_key_code=0, 1E consumed only after handshake.
- With KB_NUM_KEYPAD_EN: 69, 7D, 5A -> num=19; without: same stimulus -> no output (Enter with 0 digits). Reset asserted in CONV -> all outputs 0 next cycle.
